// File: rtl/irq_encoder8.sv
// Sequential 8-to-3 priority encoder / interrupt requester with sticky pending bits,
// a writable enable mask and a req/ack handshake that holds the granted index.
module irq_encoder8 #(
    parameter bit         EDGE       = 1'b1,
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    output logic [7:0] mask,
    output logic [7:0] pending,
    output logic       req,
    output logic [2:0] req_idx,
    output logic [7:0] req_onehot,
    input  logic       ack
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [7:0] r_irqQ;
    logic [7:0] r_mask;
    logic [7:0] r_pending;
    logic       r_req;
    logic [2:0] r_reqIdx;
    logic [7:0] r_reqOnehot;

    logic [7:0] w_edge;
    logic [7:0] w_eligible;
    logic [2:0] w_lowIdx;
    logic       w_ackTake;
    logic       w_withdraw;
    logic [7:0] w_clear;
    logic [7:0] w_pendingNext;
    logic       w_reqNext;
    logic [2:0] w_reqIdxNext;
    logic [7:0] w_reqOnehotNext;

    assign w_edge     = irq & ~r_irqQ;
    assign w_eligible = r_pending & r_mask;
    assign w_ackTake  = (r_state == GRANT) && ack;
    assign w_withdraw = (r_state == GRANT) && !ack && !r_mask[r_reqIdx];
    assign w_clear    = w_ackTake ? (8'b1 << r_reqIdx) : 8'h00;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        w_lowIdx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_lowIdx = 3'(i);
            end
        end
    end

    // Edge mode ORs new edges in after the ack clear so a same-cycle event survives.
    always_comb begin
        if (EDGE) begin
            w_pendingNext = (r_pending & ~w_clear) | w_edge;
        end else begin
            w_pendingNext = irq;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_reqNext       = r_req;
        w_reqIdxNext    = r_reqIdx;
        w_reqOnehotNext = r_reqOnehot;
        case (r_state)
            IDLE: begin
                if (w_eligible != 8'h00) begin
                    w_stateNext     = GRANT;
                    w_reqNext       = 1'b1;
                    w_reqIdxNext    = w_lowIdx;
                    w_reqOnehotNext = 8'b1 << w_lowIdx;
                end
            end
            GRANT: begin
                if (w_ackTake || w_withdraw) begin
                    w_stateNext     = IDLE;
                    w_reqNext       = 1'b0;
                    w_reqOnehotNext = 8'h00;
                end
            end
            default: begin
                w_stateNext     = IDLE;
                w_reqNext       = 1'b0;
                w_reqOnehotNext = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_irqQ      <= 8'h00;
            r_mask      <= RESET_MASK;
            r_pending   <= 8'h00;
            r_req       <= 1'b0;
            r_reqIdx    <= 3'd0;
            r_reqOnehot <= 8'h00;
        end else begin
            r_state     <= w_stateNext;
            r_irqQ      <= irq;
            r_pending   <= w_pendingNext;
            r_req       <= w_reqNext;
            r_reqIdx    <= w_reqIdxNext;
            r_reqOnehot <= w_reqOnehotNext;
            if (mask_we) begin
                r_mask <= mask_din;
            end
        end
    end

    assign mask       = r_mask;
    assign pending    = r_pending;
    assign req        = r_req;
    assign req_idx    = r_reqIdx;
    assign req_onehot = r_reqOnehot;

endmodule

// File: doc/irq_encoder8.md
Name: irq_encoder8

Overview:
- Sequential 8-to-3 priority encoder and interrupt requester: the inverse of the 3-to-8 one-hot decoder path.
- Collects eight request lines into sticky pending bits and gates them with a writable mask.
- Presents the highest-priority eligible source as a held index plus one-hot, using a req/ack handshake.
- Sits between peripheral interrupt lines and the CPU control unit, which acknowledges the granted index.

Parameters:
- EDGE, 1, 1 = rising-edge-triggered sticky pending bits; 0 = level mode (pending mirrors registered irq).
- RESET_MASK, 8'h00, value loaded into the mask register on reset.

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset.
- irq  input  8  request lines; bit i is source i; synchronous to clk.
- mask_we  input  1  mask write enable.
- mask_din  input  8  new mask value; bit = 1 enables that source.
- mask  output  8  current mask register.
- pending  output  8  current pending register.
- req  output  1  a granted request is being presented.
- req_idx  output  3  index of the granted source; stable while req = 1.
- req_onehot  output  8  one-hot of req_idx when req = 1; 8'h00 when req = 0.
- ack  input  1  CPU acknowledges the presented request; sampled only while req = 1.

Behaviour:
- Reset: mask = RESET_MASK; pending = 0; internal irq_q = 0; req = 0; req_idx = 0; req_onehot = 0; FSM = IDLE.
- Reset asserted mid-grant drops req at that same edge; no pending bit survives.
- irq_q <= irq every cycle. Edge condition per bit: irq & ~irq_q.
- An irq line already high when reset releases counts as a rising edge on the first post-reset cycle.
- Edge mode: pending[i] <= 1 on an edge. pending[i] is cleared only by an ack of index i.
- Edge mode, same-cycle set and clear on one bit: set wins, so a new event is never lost.
- Level mode: pending <= irq every cycle; ack does not modify pending.
- Mask: mask <= mask_din on posedge when mask_we = 1. The new mask affects eligibility from the next cycle.
- Eligibility: eligible = pending & mask. Priority: lowest index wins (bit 0 highest).
- State IDLE, eligible != 0: req <= 1, req_idx <= lowest set bit, req_onehot <= that bit, go to GRANT.
- State IDLE, eligible == 0: req stays 0.
- State GRANT: req_idx and req_onehot are held. A newly pending higher-priority source does not preempt.
- State GRANT, ack = 1: clear pending[req_idx] (edge mode); req <= 0; req_onehot <= 0; go to IDLE. req_idx keeps its last value.
- State GRANT, ack = 0 and mask[req_idx] = 0 (source masked while presented): withdraw. req <= 0, go to IDLE, pending bit untouched.
- ack and mask-clear in the same cycle: ack wins.
- After any grant ends, req is low for at least one cycle before the next grant.
- ack while req = 0 is ignored; no state change.
- Latency, edge mode: irq first sampled high at edge k -> pending set at edge k -> req = 1 after edge k+1.
- Latency, level mode: identical; pending registers at edge k, req at k+1.
- mask and pending outputs are direct register values (no combinational path from inputs).

Test Plan:
- Reset with irq = 8'h00, mask_din written to 8'hFF -> after the write, req = 0 and pending = 0. Then pulse irq[5] for 1 cycle -> pending = 8'h20 after edge k; req = 1, req_idx = 5, req_onehot = 8'h20 after edge k+1. ack for 1 cycle -> req = 0, pending = 8'h00.
- Priority and no preemption: mask 8'hFF, raise irq[6]; once req_idx = 6, raise irq[1] -> req_idx stays 6 until ack. After ack, one idle cycle, then req_idx = 1.
- Masking: mask 8'h00, pulse irq[3] -> pending = 8'h08 and req stays 0. Write mask 8'h08 -> req = 1, req_idx = 3 two edges after the write. Clear mask while req = 1 without ack -> req = 0 and pending still 8'h08.
- Collisions: at the ack cycle of index 2, a new irq[2] rising edge arrives -> pending[2] remains 1 and is re-granted after the one-cycle gap. Same cycle ack and mask clear of index 2 -> pending[2] cleared.
- Level mode (EDGE = 0): hold irq[4] high, ack the grant -> pending[4] stays 1 and index 4 is re-granted. Drop irq[4] -> pending = 0 next edge.
- Reset mid-grant: req = 1 with idx 7, assert reset 1 cycle -> req = 0, pending = 0, mask = RESET_MASK. ack on the following cycle has no effect.
